pwm_multi_mode: RTL and testbench

Parametrised successor to the fixed-period PWM output stage. It accepts the per-transducer pulse-width/phase stream from the silencer stage, DEPTH beats per frame, into a shadow edge buffer. On UPDATE it atomically swaps a complete frame into the active buffer. It then drives DEPTH PWM outputs against a generic CNT_W-bit time counter in one of four modes, and flags overrun and underrun frames. It sits between `silencer_pwe_selector` and the `PWM_OUT` pins.

---
 rtl/pwm_pkg.sv | 24 ++
 rtl/pwm_edge_calc.sv | 27 ++
 rtl/pwm_multi_mode.sv | 177 +++++++++++++++++
 tb/tb_pwm_multi_mode.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types for the multi-mode PWM output stage.
package pwm_pkg;

   // Default geometry of the output stage (249 transducers, 9-bit period).
   localparam int PWM_DEPTH = 249;
   localparam int PWM_CNT_W = 9;
   localparam int PWM_PH_W  = 8;

   // Output modes; MODE is latched on UPDATE.
   typedef enum logic [1:0] {
      CENTRED    = 2'd0,
      LEFT       = 2'd1,
      FORCE_LOW  = 2'd2,
      FORCE_HIGH = 2'd3
   } pwm_mode_t;

   // Rise/fall edge pair at the default counter width. Modules built with a
   // different CNT_W declare the same layout locally at their own width.
   typedef struct packed {
      logic [PWM_CNT_W-1:0] rise;
      logic [PWM_CNT_W-1:0] fall;
   } edge_t;

endpackage

// File: rtl/pwm_edge_calc.sv
// Converts one beat (pulse width + phase code) into centred and left-aligned
// edge pairs. All arithmetic wraps modulo the period 2^CNT_W.
module pwm_edge_calc #(
   parameter int CNT_W = 9,
   parameter int PH_W  = 8
) (
   input  logic [CNT_W-1:0] pulse_width,
   input  logic [PH_W-1:0]  phase,
   output logic [CNT_W-1:0] c_rise,
   output logic [CNT_W-1:0] c_fall,
   output logic [CNT_W-1:0] l_rise,
   output logic [CNT_W-1:0] l_fall
);

   logic [CNT_W-1:0] off;

   // Phase code is scaled up to counter resolution; both alignments are
   // produced so a later mode change needs no reload.
   always_comb begin
      off    = CNT_W'(phase) << (CNT_W - PH_W);
      c_rise = off - (pulse_width >> 1);
      c_fall = c_rise + pulse_width;
      l_rise = off;
      l_fall = off + pulse_width;
   end

endmodule

// File: rtl/pwm_multi_mode.sv
// Multi-mode PWM output stage: shadow edge buffer loaded beat by beat,
// atomic frame swap on UPDATE, per-channel compare against TIME_CNT.
module pwm_multi_mode
   import pwm_pkg::*;
#(
   parameter int DEPTH = 249,
   parameter int CNT_W = 9,
   parameter int PH_W  = 8
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic [CNT_W-1:0] TIME_CNT,
   input  logic             UPDATE,
   input  logic [1:0]       MODE,
   input  logic             OUTPUT_EN,
   input  logic             DIN_VALID,
   input  logic [CNT_W-1:0] PULSE_WIDTH,
   input  logic [PH_W-1:0]  PHASE,
   output logic             PWM_OUT [DEPTH],
   output logic             FRAME_READY,
   output logic             SWAPPED,
   output logic             OVERRUN,
   output logic             UNDERRUN
);

   localparam int IDX_W = $clog2(DEPTH + 1);
   localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(DEPTH);

   typedef struct packed {
      logic [CNT_W-1:0] rise;
      logic [CNT_W-1:0] fall;
   } ch_edge_t;

   // Both alignments are kept per channel.
   typedef struct packed {
      ch_edge_t c;
      ch_edge_t l;
   } ch_edges_t;

   // ---------------------------------------------------------------- beat edges
   logic [CNT_W-1:0] c_rise, c_fall, l_rise, l_fall;
   ch_edges_t        beat_edges;

   pwm_edge_calc #(
      .CNT_W (CNT_W),
      .PH_W  (PH_W)
   ) u_edge_calc (
      .pulse_width (PULSE_WIDTH),
      .phase       (PHASE),
      .c_rise      (c_rise),
      .c_fall      (c_fall),
      .l_rise      (l_rise),
      .l_fall      (l_fall)
   );

   // Pack the calculated edges into the per-channel storage layout.
   always_comb begin
      beat_edges.c.rise = c_rise;
      beat_edges.c.fall = c_fall;
      beat_edges.l.rise = l_rise;
      beat_edges.l.fall = l_fall;
   end

   // ---------------------------------------------------------------- load/swap control
   logic [IDX_W-1:0] idx_q, idx_d;
   pwm_mode_t        mode_q, mode_d;
   logic             frame_ready_q, frame_ready_d;
   logic             swapped_q, swapped_d;
   logic             overrun_q, overrun_d;
   logic             underrun_q, underrun_d;

   logic             full;
   logic             beat_wr;
   logic [IDX_W-1:0] wr_idx;
   logic             swap;

   // A beat that lands with UPDATE always opens the next frame at index 0;
   // swap/underrun decisions use the load count from before this cycle.
   always_comb begin
      full          = (idx_q == IDX_FULL);
      beat_wr       = DIN_VALID && (UPDATE || !full);
      wr_idx        = UPDATE ? '0 : idx_q;
      swap          = UPDATE && full;
      idx_d         = idx_q;
      mode_d        = mode_q;
      if (UPDATE) begin
         idx_d  = DIN_VALID ? IDX_W'(1) : '0;
         mode_d = pwm_mode_t'(MODE);
      end else if (beat_wr) begin
         idx_d = idx_q + IDX_W'(1);
      end
      frame_ready_d = (idx_d == IDX_FULL);
      swapped_d     = swap;
      underrun_d    = UPDATE && (idx_q != '0) && !full;
      overrun_d     = DIN_VALID && !UPDATE && full;
   end

   // Control and status registers.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         idx_q         <= '0;
         mode_q        <= CENTRED;
         frame_ready_q <= 1'b0;
         swapped_q     <= 1'b0;
         overrun_q     <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         idx_q         <= idx_d;
         mode_q        <= mode_d;
         frame_ready_q <= frame_ready_d;
         swapped_q     <= swapped_d;
         overrun_q     <= overrun_d;
         underrun_q    <= underrun_d;
      end
   end

   assign FRAME_READY = frame_ready_q;
   assign SWAPPED     = swapped_q;
   assign OVERRUN     = overrun_q;
   assign UNDERRUN    = underrun_q;

   // ---------------------------------------------------------------- channels
   for (genvar i = 0; i < DEPTH; i++) begin : g_ch
      localparam logic [IDX_W-1:0] CH_IDX = IDX_W'(i);

      ch_edges_t shadow_q, shadow_d;
      ch_edges_t active_q, active_d;
      ch_edge_t  sel;
      logic      hit;
      logic      pwm_q, pwm_d;

      // Shadow takes the beat addressed to this channel; active copies the
      // whole shadow (pre-cycle contents) on a swap.
      always_comb begin
         shadow_d = shadow_q;
         if (beat_wr && (wr_idx == CH_IDX)) begin
            shadow_d = beat_edges;
         end
         active_d = swap ? shadow_q : active_q;
      end

      // Compare the active edge pair for the current mode against TIME_CNT;
      // rise > fall means the pulse wraps across the period boundary.
      always_comb begin
         sel = (mode_q == CENTRED) ? active_q.c : active_q.l;
         if (sel.rise <= sel.fall) begin
            hit = (TIME_CNT >= sel.rise) && (TIME_CNT < sel.fall);
         end else begin
            hit = (TIME_CNT >= sel.rise) || (TIME_CNT < sel.fall);
         end
         pwm_d = 1'b0;
         if (OUTPUT_EN) begin
            case (mode_q)
               FORCE_LOW:  pwm_d = 1'b0;
               FORCE_HIGH: pwm_d = 1'b1;
               default:    pwm_d = hit;
            endcase
         end
      end

      // Per-channel buffers and registered output.
      always_ff @(posedge CLK or negedge RESET_N) begin
         if (!RESET_N) begin
            shadow_q <= '0;
            active_q <= '0;
            pwm_q    <= 1'b0;
         end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pwm_q    <= pwm_d;
         end
      end

      assign PWM_OUT[i] = pwm_q;
   end

endmodule

// File: tb/tb_pwm_multi_mode.sv
// Directed bench for pwm_multi_mode with hand-computed expectations.
module tb_pwm_multi_mode;

   localparam int DEPTH = 249;
   localparam int CNT_W = 9;
   localparam int PH_W  = 8;

   logic             clk;
   logic             rst_n;
   logic [CNT_W-1:0] time_cnt;
   logic             update;
   logic [1:0]       mode;
   logic             output_en;
   logic             din_valid;
   logic [CNT_W-1:0] pulse_width;
   logic [PH_W-1:0]  phase;
   logic             pwm_out [DEPTH];
   logic             frame_ready, swapped, overrun, underrun;
   logic [DEPTH-1:0] pwm_vec;

   int n_cmp = 0;
   int n_err = 0;

   pwm_multi_mode #(.DEPTH(DEPTH), .CNT_W(CNT_W), .PH_W(PH_W)) dut (
      .CLK         (clk),
      .RESET_N     (rst_n),
      .TIME_CNT    (time_cnt),
      .UPDATE      (update),
      .MODE        (mode),
      .OUTPUT_EN   (output_en),
      .DIN_VALID   (din_valid),
      .PULSE_WIDTH (pulse_width),
      .PHASE       (phase),
      .PWM_OUT     (pwm_out),
      .FRAME_READY (frame_ready),
      .SWAPPED     (swapped),
      .OVERRUN     (overrun),
      .UNDERRUN    (underrun)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      pwm_vec = '0;
      for (int i = 0; i < DEPTH; i++) pwm_vec[i] = pwm_out[i];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ch0 gets pw0/ph0, ch1 is always PW=30 PHASE=10, the rest are silent.
   task automatic load_range(input int first, input int last,
                             input logic [CNT_W-1:0] pw0, input logic [PH_W-1:0] ph0);
      for (int i = first; i <= last; i++) begin
         din_valid = 1'b1;
         if (i == 0) begin
            pulse_width = pw0; phase = ph0;
         end else if (i == 1) begin
            pulse_width = 9'd30; phase = 8'd10;
         end else begin
            pulse_width = '0; phase = '0;
         end
         tick();
      end
      din_valid = 1'b0;
   endtask

   task automatic do_update(input logic [1:0] m);
      update = 1'b1;
      mode   = m;
      tick();
      update = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if (pwm_vec !== '0) begin n_err++; $display("FAIL reset_pwm: got %h want 0", pwm_vec); end
      n_cmp++;
      if ({frame_ready, swapped, overrun, underrun} !== 4'b0000) begin
         n_err++; $display("FAIL reset_flags: got %b want 0000", {frame_ready, swapped, overrun, underrun});
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      tick();
      n_cmp++;
      if (pwm_vec !== '0) begin n_err++; $display("FAIL post_reset_pwm: got %h want 0", pwm_vec); end
   endtask

   task automatic test_centred();
      logic e0, e1;
      load_range(0, DEPTH-1, 9'd100, 8'd64);
      n_cmp++;
      if (frame_ready !== 1'b1) begin n_err++; $display("FAIL centred_ready: got %b want 1", frame_ready); end
      do_update(2'd0);
      n_cmp++;
      if ({swapped, underrun, frame_ready} !== 3'b100) begin
         n_err++; $display("FAIL centred_swap: got %b want 100", {swapped, underrun, frame_ready});
      end
      tick();
      n_cmp++;
      if (swapped !== 1'b0) begin n_err++; $display("FAIL centred_swap_pulse: got %b want 0", swapped); end
      for (int tc = 0; tc < 512; tc++) begin
         time_cnt = CNT_W'(tc);
         tick();
         e0 = (tc >= 78) && (tc <= 177);
         e1 = (tc >= 5) && (tc <= 34);
         n_cmp++;
         if ({pwm_out[0], pwm_out[1]} !== {e0, e1}) begin
            n_err++; $display("FAIL centred_sweep tc=%0d: got %b%b want %b%b", tc, pwm_out[0], pwm_out[1], e0, e1);
         end
      end
   endtask

   task automatic test_wrap();
      logic e0;
      load_range(0, DEPTH-1, 9'd100, 8'd0);
      do_update(2'd0);
      n_cmp++;
      if (swapped !== 1'b1) begin n_err++; $display("FAIL wrap_swap: got %b want 1", swapped); end
      for (int tc = 0; tc < 512; tc++) begin
         time_cnt = CNT_W'(tc);
         tick();
         e0 = (tc >= 462) || (tc <= 49);
         n_cmp++;
         if (pwm_out[0] !== e0) begin
            n_err++; $display("FAIL wrap_sweep tc=%0d: got %b want %b", tc, pwm_out[0], e0);
         end
      end
   endtask

   task automatic test_zero_width();
      load_range(0, DEPTH-1, 9'd0, 8'd64);
      do_update(2'd0);
      for (int tc = 0; tc < 512; tc++) begin
         time_cnt = CNT_W'(tc);
         tick();
         n_cmp++;
         if (pwm_out[0] !== 1'b0) begin
            n_err++; $display("FAIL zero_width tc=%0d: got %b want 0", tc, pwm_out[0]);
         end
      end
   endtask

   task automatic test_mode_switch();
      logic e1;
      do_update(2'd1);
      n_cmp++;
      if ({swapped, underrun} !== 2'b00) begin
         n_err++; $display("FAIL mode_switch_flags: got %b want 00", {swapped, underrun});
      end
      for (int tc = 0; tc < 512; tc++) begin
         time_cnt = CNT_W'(tc);
         tick();
         e1 = (tc >= 20) && (tc <= 49);
         n_cmp++;
         if (pwm_out[1] !== e1) begin
            n_err++; $display("FAIL left_sweep tc=%0d: got %b want %b", tc, pwm_out[1], e1);
         end
      end
   endtask

   task automatic test_underrun();
      load_range(0, 4, 9'd200, 8'd0);
      n_cmp++;
      if (frame_ready !== 1'b0) begin n_err++; $display("FAIL partial_ready: got %b want 0", frame_ready); end
      do_update(2'd1);
      n_cmp++;
      if ({underrun, swapped} !== 2'b10) begin
         n_err++; $display("FAIL underrun_flags: got %b want 10", {underrun, swapped});
      end
      tick();
      n_cmp++;
      if (underrun !== 1'b0) begin n_err++; $display("FAIL underrun_pulse: got %b want 0", underrun); end
      time_cnt = 9'd10;
      tick();
      n_cmp++;
      if (pwm_out[0] !== 1'b0) begin n_err++; $display("FAIL underrun_ch0_kept: got %b want 0", pwm_out[0]); end
      time_cnt = 9'd25;
      tick();
      n_cmp++;
      if (pwm_out[1] !== 1'b1) begin n_err++; $display("FAIL underrun_ch1_kept: got %b want 1", pwm_out[1]); end
   endtask

   task automatic test_overrun();
      int           tcs [4] = '{127, 128, 227, 228};
      logic [3:0]   exp0 = 4'b0110;
      load_range(0, DEPTH-1, 9'd100, 8'd64);
      n_cmp++;
      if ({frame_ready, overrun} !== 2'b10) begin
         n_err++; $display("FAIL overrun_pre: got %b want 10", {frame_ready, overrun});
      end
      din_valid = 1'b1; pulse_width = 9'd500; phase = 8'd0;
      tick();
      din_valid = 1'b0;
      n_cmp++;
      if ({overrun, frame_ready} !== 2'b11) begin
         n_err++; $display("FAIL overrun_pulse: got %b want 11", {overrun, frame_ready});
      end
      tick();
      n_cmp++;
      if ({overrun, frame_ready} !== 2'b01) begin
         n_err++; $display("FAIL overrun_single: got %b want 01", {overrun, frame_ready});
      end
      do_update(2'd1);
      n_cmp++;
      if (swapped !== 1'b1) begin n_err++; $display("FAIL overrun_swap: got %b want 1", swapped); end
      for (int k = 0; k < 4; k++) begin
         time_cnt = CNT_W'(tcs[k]);
         tick();
         n_cmp++;
         if (pwm_out[0] !== exp0[k]) begin
            n_err++; $display("FAIL overrun_ch0 tc=%0d: got %b want %b", tcs[k], pwm_out[0], exp0[k]);
         end
      end
      time_cnt = 9'd10;
      tick();
      n_cmp++;
      if (pwm_out[DEPTH-1] !== 1'b0) begin
         n_err++; $display("FAIL overrun_last_ch: got %b want 0", pwm_out[DEPTH-1]);
      end
   endtask

   task automatic test_back_to_back();
      int         tcs [4] = '{199, 200, 249, 250};
      logic [3:0] exp0 = 4'b0110;
      load_range(0, DEPTH-2, 9'd100, 8'd64);
      din_valid = 1'b1; pulse_width = 9'd50; phase = 8'd100;
      update = 1'b1; mode = 2'd1;
      tick();
      din_valid = 1'b0; update = 1'b0;
      n_cmp++;
      if ({underrun, swapped, frame_ready} !== 3'b100) begin
         n_err++; $display("FAIL coincident_flags: got %b want 100", {underrun, swapped, frame_ready});
      end
      load_range(1, DEPTH-2, 9'd0, 8'd0);
      n_cmp++;
      if (frame_ready !== 1'b0) begin n_err++; $display("FAIL coincident_not_ready: got %b want 0", frame_ready); end
      load_range(DEPTH-1, DEPTH-1, 9'd0, 8'd0);
      n_cmp++;
      if (frame_ready !== 1'b1) begin n_err++; $display("FAIL coincident_ready: got %b want 1", frame_ready); end
      do_update(2'd1);
      n_cmp++;
      if (swapped !== 1'b1) begin n_err++; $display("FAIL coincident_swap: got %b want 1", swapped); end
      for (int k = 0; k < 4; k++) begin
         time_cnt = CNT_W'(tcs[k]);
         tick();
         n_cmp++;
         if (pwm_out[0] !== exp0[k]) begin
            n_err++; $display("FAIL coincident_ch0 tc=%0d: got %b want %b", tcs[k], pwm_out[0], exp0[k]);
         end
      end
   endtask

   task automatic test_force_and_enable();
      do_update(2'd3);
      n_cmp++;
      if ({swapped, underrun} !== 2'b00) begin
         n_err++; $display("FAIL force_flags: got %b want 00", {swapped, underrun});
      end
      tick();
      n_cmp++;
      if (pwm_vec !== {DEPTH{1'b1}}) begin n_err++; $display("FAIL force_high: got %h want all ones", pwm_vec); end
      output_en = 1'b0;
      tick();
      n_cmp++;
      if (pwm_vec !== '0) begin n_err++; $display("FAIL output_en_low: got %h want 0", pwm_vec); end
      output_en = 1'b1;
      tick();
      n_cmp++;
      if (pwm_vec !== {DEPTH{1'b1}}) begin n_err++; $display("FAIL output_en_back: got %h want all ones", pwm_vec); end
   endtask

   task automatic test_reset_mid_load();
      load_range(0, DEPTH-1, 9'd100, 8'd64);
      n_cmp++;
      if (frame_ready !== 1'b1) begin n_err++; $display("FAIL pre_reset_ready: got %b want 1", frame_ready); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({pwm_vec != '0, frame_ready} !== 2'b00) begin
         n_err++; $display("FAIL reset_mid: got pwm %h ready %b want 0/0", pwm_vec, frame_ready);
      end
      @(posedge clk);
      #1 rst_n = 1'b1;
      do_update(2'd0);
      n_cmp++;
      if ({swapped, underrun} !== 2'b00) begin
         n_err++; $display("FAIL reset_update_flags: got %b want 00", {swapped, underrun});
      end
      load_range(0, DEPTH-2, 9'd100, 8'd64);
      n_cmp++;
      if (frame_ready !== 1'b0) begin n_err++; $display("FAIL reset_refill_partial: got %b want 0", frame_ready); end
      load_range(DEPTH-1, DEPTH-1, 9'd0, 8'd0);
      n_cmp++;
      if (frame_ready !== 1'b1) begin n_err++; $display("FAIL reset_refill_full: got %b want 1", frame_ready); end
   endtask

   initial begin
      rst_n = 1'b1; time_cnt = '0; update = 1'b0; mode = 2'd0; output_en = 1'b1;
      din_valid = 1'b0; pulse_width = '0; phase = '0;
      test_reset();
      test_centred();
      test_wrap();
      test_zero_width();
      test_mode_switch();
      test_underrun();
      test_overrun();
      test_back_to_back();
      test_force_and_enable();
      test_reset_mid_load();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
